// File: rtl/baud_config.sv
// UART baud configuration loader: fetches id/baud from EEPROM, validates,
// falls back to defaults, and computes a rounded clock divider.
module baud_config #(
  parameter int unsigned CLK_FREQ       = 16000000,
  parameter logic [7:0]  DEFAULT_ID     = 8'h00,
  parameter int unsigned DEFAULT_BAUD   = 115200,
  parameter int unsigned MIN_BAUD       = 9600,
  parameter int unsigned MAX_BAUD       = 3000000,
  parameter int unsigned TIMEOUT_CYCLES = 16000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        eeprom_read,
  input  logic        eeprom_data_ready,
  input  logic [7:0]  eeprom_id,
  input  logic [31:0] eeprom_baudrate,
  output logic [7:0]  id,
  output logic [31:0] baudrate,
  output logic [31:0] clk_div,
  output logic        config_valid,
  output logic        used_default,
  output logic        busy
);

  localparam logic [31:0] CLK_W  = 32'(CLK_FREQ);
  localparam logic [31:0] DEF_W  = 32'(DEFAULT_BAUD);
  localparam logic [31:0] MIN_W  = 32'(MIN_BAUD);
  localparam logic [31:0] MAX_W  = 32'(MAX_BAUD);
  localparam logic [31:0] TMO_W  = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_EEPROM,
    VALIDATE,
    DIVIDE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic        auto_pend;
  logic [7:0]  w_id;
  logic [31:0] w_baud;
  logic        w_dflt;
  logic [31:0] tmo_cnt;
  logic [4:0]  div_cnt;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;

  logic        capt_ok;
  logic        timeout;
  logic [31:0] init_b;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        ge;

  assign capt_ok = (w_baud >= MIN_W) &&
                   (w_baud <= MAX_W) &&
                   (w_id != 8'hFF);
  assign timeout = (tmo_cnt <= 32'd1);
  assign init_b  = (state == VALIDATE && capt_ok) ? w_baud : DEF_W;

  // Remainder stays below divisor, so a wrapped 32-bit subtract is exact.
  assign rem_sh  = {rem, quo[31]};
  assign ge      = rem_sh[32] || (rem_sh[31:0] >= divisor);
  assign rem_sub = rem_sh[31:0] - divisor;

  assign busy        = (state != IDLE);
  assign eeprom_read = (state == REQUEST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:        if (start || auto_pend) state_nx = REQUEST;
      REQUEST:     state_nx = WAIT_EEPROM;
      WAIT_EEPROM: begin
        if (eeprom_data_ready) state_nx = VALIDATE;
        else if (timeout)      state_nx = DIVIDE;
      end
      VALIDATE:    state_nx = DIVIDE;
      DIVIDE:      if (div_cnt == 5'd31) state_nx = DONE;
      DONE:        state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_pend    <= 1'b1;
      id           <= DEFAULT_ID;
      baudrate     <= DEF_W;
      clk_div      <= '0;
      config_valid <= 1'b0;
      used_default <= 1'b0;
      w_id         <= '0;
      w_baud       <= '0;
      w_dflt       <= 1'b0;
      tmo_cnt      <= '0;
      div_cnt      <= '0;
      divisor      <= '0;
      quo          <= '0;
      rem          <= '0;
    end else begin
      unique case (state)
        IDLE: auto_pend <= 1'b0;
        REQUEST: begin
          config_valid <= 1'b0;
          tmo_cnt      <= TMO_W;
          w_dflt       <= 1'b0;
        end
        WAIT_EEPROM: begin
          if (eeprom_data_ready) begin
            w_id   <= eeprom_id;
            w_baud <= eeprom_baudrate;
          end else if (timeout) begin
            w_id    <= DEFAULT_ID;
            w_baud  <= DEF_W;
            w_dflt  <= 1'b1;
            divisor <= init_b;
            quo     <= CLK_W + (init_b >> 1);
            rem     <= '0;
            div_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
          end
        end
        VALIDATE: begin
          if (!capt_ok) begin
            w_id   <= DEFAULT_ID;
            w_baud <= DEF_W;
            w_dflt <= 1'b1;
          end
          divisor <= init_b;
          quo     <= CLK_W + (init_b >> 1);
          rem     <= '0;
          div_cnt <= '0;
        end
        DIVIDE: begin
          rem     <= ge ? rem_sub : rem_sh[31:0];
          quo     <= {quo[30:0], ge};
          div_cnt <= div_cnt + 5'd1;
        end
        DONE: begin
          id           <= w_id;
          baudrate     <= w_baud;
          clk_div      <= quo;
          used_default <= w_dflt;
          config_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
